// File: rtl/serial_adder_seq.sv
// serial_adder_seq: bit-serial adder controller.
// Accepts two WIDTH-bit operands and a carry-in, then feeds one bit pair per
// clock (LSB first) through a one-bit full-adder cell. The carry is kept in a
// flop between bits. Sum bits collect in a shift register, and the result is
// presented over a valid/ready handshake.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    // WIDTH=2 still needs a 1-bit counter; $clog2 gives exactly that.
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_c;

    // One-bit full-adder cell: purely combinational, fed only from registers.
    always_comb begin
        fa_s = a_q[0] ^ b_q[0] ^ carry_q;
        fa_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = fa_c;
                // Hold the counter on the last bit so it never wraps,
                // even when WIDTH is a power of two.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            // The unused encoding 2'b11 falls back to IDLE.
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are decoded from registered state only.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = carry_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Scoreboard bench for serial_adder_seq at WIDTH = 2, 8 and 32.
// Drivers push (a+b+cin) into a per-width queue at accept time.
// A negedge monitor pops the queue and compares on every output handshake.
module tb_serial_adder_seq;

    logic clk = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   n_done = 0;

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string nm, input logic [64:0] act,
                       input logic [64:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_w
        localparam int W = (g == 0) ? 2 : ((g == 1) ? 8 : 32);
        localparam int RST_AT = (W > 3) ? 3 : 1;
        localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;
        localparam int NRAND = 340;

        logic         rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
        logic [W-1:0] op_a, op_b, sum;
        logic         rdy_rand, rdy_force, rnd_rdy;
        logic [64:0]  exp_q[$];

        assign out_ready = rdy_rand ? rnd_rdy : rdy_force;

        serial_adder_seq #(.WIDTH(W)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .op_a     (op_a),
            .op_b     (op_b),
            .cin      (cin),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .sum      (sum),
            .cout     (cout),
            .busy     (busy)
        );

        // Reference: plain integer addition; bit W of the result is the carry-out.
        function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b,
                                              input logic c);
            return {1'b0, a & MASK} + {1'b0, b & MASK} + {64'd0, c};
        endfunction

        // Random consumer backpressure.
        initial rnd_rdy = 1'b0;
        always begin
            @(posedge clk);
            #1;
            rnd_rdy = 1'($urandom_range(0, 1));
        end

        // Monitor: handshake invariants every cycle; pop and compare on each result.
        always @(negedge clk) begin
            if (rst_n) begin
                chk((in_ready == !busy) && !(in_ready && out_valid),
                    $sformatf("w%0d handshake invariant", W),
                    {in_ready, out_valid, busy}, {1'b0, 1'b0, 1'b0});
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, $sformatf("w%0d unexpected result", W), {cout, sum}, 0);
                    end else begin
                        logic [64:0] e;
                        e = exp_q.pop_front();
                        chk({cout, sum} == e[W:0], $sformatf("w%0d result", W),
                            {cout, sum}, e[W:0]);
                    end
                end
            end
        end

        // Present operands, wait (bounded) for in_ready, push expectation,
        // return just after the accepting edge.
        task automatic send(input logic [63:0] a, input logic [63:0] b, input logic c,
                            output bit ok);
            int t;
            op_a     = a[W-1:0];
            op_b     = b[W-1:0];
            cin      = c;
            in_valid = 1'b1;
            t = 0;
            while (!in_ready && t < 300) begin
                @(posedge clk);
                #1;
                t++;
            end
            ok = in_ready;
            if (!ok) begin
                chk(1'b0, $sformatf("w%0d accept timeout", W), 0, 1);
                in_valid = 1'b0;
                return;
            end
            exp_q.push_back(model(a, b, c));
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        endtask

        // Operation with latency and occupancy checks (out_ready held high).
        task automatic op_lat(input logic [63:0] a, input logic [63:0] b, input logic c);
            bit ok;
            send(a, b, c, ok);
            if (!ok) return;
            for (int k = 1; k <= W; k++) begin
                @(posedge clk);
                #1;
                if (k == 1)
                    chk(busy && !in_ready, $sformatf("w%0d busy after accept", W),
                        {busy, in_ready}, 2'b10);
                if (k == W - 1)
                    chk(!out_valid, $sformatf("w%0d early out_valid", W), out_valid, 0);
                if (k == W)
                    chk(out_valid, $sformatf("w%0d out_valid at E+W", W), out_valid, 1);
            end
            @(posedge clk);
            #1;
            chk(in_ready && !out_valid, $sformatf("w%0d back to idle", W),
                {in_ready, out_valid}, 2'b10);
        endtask

        task automatic wait_empty(input string nm);
            int t;
            t = 0;
            while (exp_q.size() != 0 && t < 2000) begin
                @(posedge clk);
                #1;
                t++;
            end
            chk(exp_q.size() == 0, $sformatf("w%0d drain %s", W, nm), exp_q.size(), 0);
        endtask

        initial begin
            bit ok;
            int t;
            logic [W-1:0] s0;
            logic c0;
            in_valid  = 1'b0;
            op_a      = '0;
            op_b      = '0;
            cin       = 1'b0;
            rdy_rand  = 1'b0;
            rdy_force = 1'b1;
            rst_n     = 1'b1;
            #1 rst_n  = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk(in_ready && !out_valid && !busy && sum == '0 && !cout,
                $sformatf("w%0d reset outputs", W), {in_ready, out_valid, busy, cout, sum},
                {4'b1000, {W{1'b0}}});
            @(negedge clk);
            rst_n = 1'b1;

            // Directed patterns, including all-ones with carry and the carry-out wrap.
            op_lat(64'h5A, 64'h3C, 1'b0);
            op_lat(64'hFF, 64'h01, 1'b0);
            op_lat(64'hFF, 64'hFF, 1'b1);
            op_lat(64'h00, 64'h00, 1'b0);
            op_lat(64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1);

            // Backpressure in DONE while in_valid and op_a wiggle.
            rdy_force = 1'b0;
            send(64'h33, 64'h44, 1'b1, ok);
            t = 0;
            while (!out_valid && t < 200) begin
                @(posedge clk);
                #1;
                t++;
            end
            chk(out_valid, $sformatf("w%0d reach DONE", W), out_valid, 1);
            s0 = sum;
            c0 = cout;
            for (int k = 0; k < 5; k++) begin
                in_valid = ~in_valid;
                op_a     = W'($urandom);
                @(posedge clk);
                #1;
                chk(sum == s0 && cout == c0, $sformatf("w%0d stall hold", W),
                    {cout, sum}, {c0, s0});
                chk(!in_ready && out_valid, $sformatf("w%0d stall flags", W),
                    {in_ready, out_valid}, 2'b01);
            end
            in_valid  = 1'b0;
            rdy_force = 1'b1;
            @(posedge clk);
            #1;
            chk(in_ready && !out_valid, $sformatf("w%0d release to idle", W),
                {in_ready, out_valid}, 2'b10);

            // Asynchronous reset mid-operation aborts without a result.
            send(64'hA5, 64'h5A, 1'b0, ok);
            repeat (RST_AT) @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            chk(in_ready && !out_valid && !busy && sum == '0 && !cout,
                $sformatf("w%0d async reset", W), {in_ready, out_valid, busy, cout, sum},
                {4'b1000, {W{1'b0}}});
            exp_q.delete();
            @(negedge clk);
            rst_n = 1'b1;
            op_lat(64'h01, 64'h01, 1'b0);

            // Operands changing during RUN must not matter.
            send(64'h9C, 64'h27, 1'b1, ok);
            for (int k = 0; k < W; k++) begin
                op_a = W'($urandom);
                op_b = W'($urandom);
                cin  = 1'($urandom);
                @(posedge clk);
                #1;
            end
            wait_empty("mutation");

            // Random traffic with input gaps and output stalls.
            rdy_rand = 1'b1;
            for (int n = 0; n < NRAND; n++) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
                send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), ok);
            end
            wait_empty("random");
            n_done++;
        end
    end

    initial begin
        int t;
        t = 0;
        while (n_done < 3 && t < 80000) begin
            @(posedge clk);
            t++;
        end
        if (n_done < 3) chk(1'b0, "global timeout", n_done, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
